// File: rtl/wash_sequencer.sv
// wash_sequencer: washing-machine controller.
// Holds the machine state and a packed vector of the time left in each phase. It loads
// program presets, counts phases down on the time-base tick, and handles pause, lid-open
// error and finish/buzzer sequencing.
//
// Parameters:
//   FINISH_HOLD  number of tick pulses the buzzer sounds in finish before shutdown
// Ports:
//   cp         in   clock
//   reset      in   synchronous active-high reset
//   power_btn  in   power toggle pulse
//   start_btn  in   start / pause / resume pulse
//   mode_btn   in   preset select pulse (set state only)
//   lid_open   in   lid level, 1 = open
//   tick       in   one unit of phase time
//   state      out  0 shutDown, 1 begin, 2 set, 3 run, 4 error, 5 pause, 6 finish
//   msg        out  remaining units, f7..f0 = [25:23],[22:19],[18:16],[15:13],[12:10],
//                   [9:6],[5:3],[2:0]
//   buzzer     out  high in error and finish
// Build option:
//   WASH_LID_LOCK_EN  enables lid handling (error state, start blocked while lid open).
//                     Without it the lid input is ignored.
module wash_sequencer #(
  parameter int unsigned FINISH_HOLD = 3
) (
  input  logic        cp,
  input  logic        reset,
  input  logic        power_btn,
  input  logic        start_btn,
  input  logic        mode_btn,
  input  logic        lid_open,
  input  logic        tick,
  output logic [2:0]  state,
  output logic [25:0] msg,
  output logic        buzzer
);

  localparam int unsigned HoldW = (FINISH_HOLD < 2) ? 1 : $clog2(FINISH_HOLD + 1);

  typedef enum logic [2:0] {
    StShutDown = 3'd0,
    StBegin    = 3'd1,
    StSet      = 3'd2,
    StRun      = 3'd3,
    StError    = 3'd4,
    StPause    = 3'd5,
    StFinish   = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [25:0]      msg_q, msg_d;
  logic [1:0]       preset_q, preset_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             buzzer_q, buzzer_d;

  logic             lid_evt;
  logic [7:0]       field_nz;
  logic [25:0]      dec_msg;

`ifdef WASH_LID_LOCK_EN
  assign lid_evt = lid_open;
`else
  logic unused_lid;
  assign unused_lid = lid_open;
  assign lid_evt    = 1'b0;
`endif

  function automatic logic [25:0] preset_msg(input logic [1:0] idx);
    case (idx)
      2'd0:    preset_msg = {3'd2, 4'd9,  3'd3, 3'd2, 3'd3, 4'd6,  3'd2, 3'd4};
      2'd1:    preset_msg = {3'd0, 4'd5,  3'd2, 3'd0, 3'd2, 4'd4,  3'd0, 3'd3};
      2'd2:    preset_msg = {3'd4, 4'd15, 3'd5, 3'd3, 3'd5, 4'd10, 3'd3, 3'd6};
      default: preset_msg = {3'd0, 4'd0,  3'd0, 3'd0, 3'd0, 4'd8,  3'd0, 3'd5};
    endcase
  endfunction

  assign field_nz = {|msg_q[25:23], |msg_q[22:19], |msg_q[18:16], |msg_q[15:13],
                     |msg_q[12:10], |msg_q[9:6],   |msg_q[5:3],   |msg_q[2:0]};

  // Decrement the highest non-zero field by subtracting one at its LSB. The field is
  // non-zero so no borrow leaves it; an all-zero vector is left untouched (saturation).
  always_comb begin
    dec_msg = msg_q;
    if      (field_nz[7]) dec_msg = msg_q - 26'(1 << 23);
    else if (field_nz[6]) dec_msg = msg_q - 26'(1 << 19);
    else if (field_nz[5]) dec_msg = msg_q - 26'(1 << 16);
    else if (field_nz[4]) dec_msg = msg_q - 26'(1 << 13);
    else if (field_nz[3]) dec_msg = msg_q - 26'(1 << 10);
    else if (field_nz[2]) dec_msg = msg_q - 26'(1 << 6);
    else if (field_nz[1]) dec_msg = msg_q - 26'(1 << 3);
    else if (field_nz[0]) dec_msg = msg_q - 26'(1);
  end

  always_comb begin
    state_d  = state_q;
    msg_d    = msg_q;
    preset_d = preset_q;
    hold_d   = hold_q;

    if (power_btn) begin
      if (state_q == StShutDown) begin
        state_d = StBegin;
      end else begin
        state_d  = StShutDown;
        msg_d    = '0;
        preset_d = '0;
        hold_d   = '0;
      end
    end else begin
      case (state_q)
        StShutDown: ;
        StBegin: begin
          msg_d    = preset_msg(2'd0);
          preset_d = 2'd0;
          state_d  = StSet;
        end
        StSet: begin
          if (start_btn) begin
            state_d = StRun;
          end else if (mode_btn) begin
            preset_d = preset_q + 2'd1;
            msg_d    = preset_msg(preset_q + 2'd1);
          end
        end
        StRun: begin
          if (lid_evt) begin
            state_d = StError;
          end else if (start_btn) begin
            state_d = StPause;
          end else if (msg_q == '0) begin
            state_d = StFinish;
          end else if (tick) begin
            msg_d = dec_msg;
            // Last decrement and entry into finish share one edge.
            if (dec_msg == '0) state_d = StFinish;
          end
        end
        StPause: begin
          if (start_btn && !lid_evt) state_d = StRun;
        end
        StError: begin
          if (!lid_evt) state_d = StPause;
        end
        StFinish: begin
          msg_d = '0;
          if (FINISH_HOLD == 0) begin
            state_d = StShutDown;
            hold_d  = '0;
          end else if (tick) begin
            if (hold_q == HoldW'(FINISH_HOLD - 1)) begin
              state_d = StShutDown;
              hold_d  = '0;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = StShutDown;
          msg_d   = '0;
        end
      endcase
    end
  end

  // Buzzer decoded from the next state so it rises on the edge entering error/finish.
  assign buzzer_d = (state_d == StError) || (state_d == StFinish);

  always_ff @(posedge cp) begin
    if (reset) begin
      state_q  <= StShutDown;
      msg_q    <= '0;
      preset_q <= '0;
      hold_q   <= '0;
      buzzer_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      msg_q    <= msg_d;
      preset_q <= preset_d;
      hold_q   <= hold_d;
      buzzer_q <= buzzer_d;
    end
  end

  assign state  = state_q;
  assign msg    = msg_q;
  assign buzzer = buzzer_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed self-checking bench for wash_sequencer (default FINISH_HOLD = 3).
module tb_wash_sequencer;

  logic        cp = 1'b0;
  logic        reset = 1'b1;
  logic        power_btn = 1'b0;
  logic        start_btn = 1'b0;
  logic        mode_btn = 1'b0;
  logic        lid_open = 1'b0;
  logic        tick = 1'b0;
  logic [2:0]  state;
  logic [25:0] msg;
  logic        buzzer;

  int tests = 0;
  int fails = 0;

  localparam logic [25:0] P0 = {3'd2, 4'd9,  3'd3, 3'd2, 3'd3, 4'd6,  3'd2, 3'd4};
  localparam logic [25:0] P1 = {3'd0, 4'd5,  3'd2, 3'd0, 3'd2, 4'd4,  3'd0, 3'd3};
  localparam logic [25:0] P2 = {3'd4, 4'd15, 3'd5, 3'd3, 3'd5, 4'd10, 3'd3, 3'd6};
  localparam logic [25:0] P3 = {3'd0, 4'd0,  3'd0, 3'd0, 3'd0, 4'd8,  3'd0, 3'd5};
  localparam logic [25:0] P1D = {3'd0, 4'd4, 3'd2, 3'd0, 3'd2, 4'd4, 3'd0, 3'd3};
  localparam logic [25:0] P0D = {3'd1, 4'd9, 3'd3, 3'd2, 3'd3, 4'd6, 3'd2, 3'd4};

  wash_sequencer #(.FINISH_HOLD(3)) dut (
    .cp        (cp),
    .reset     (reset),
    .power_btn (power_btn),
    .start_btn (start_btn),
    .mode_btn  (mode_btn),
    .lid_open  (lid_open),
    .tick      (tick),
    .state     (state),
    .msg       (msg),
    .buzzer    (buzzer)
  );

  always #5 cp = ~cp;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge cp);
    #1;
  endtask

  // One clock with the given pulses applied, then pulses released.
  task automatic cyc(input logic pw, input logic st, input logic md, input logic tk);
    power_btn = pw;
    start_btn = st;
    mode_btn  = md;
    tick      = tk;
    step();
    power_btn = 1'b0;
    start_btn = 1'b0;
    mode_btn  = 1'b0;
    tick      = 1'b0;
  endtask

  initial begin
    step();
    step();
    reset = 1'b0;
    check("reset_state", 32'(state), 32'd0);
    check("reset_msg", 32'(msg), 32'd0);
    check("reset_buzzer", 32'(buzzer), 32'd0);

    cyc(1, 0, 0, 0);
    check("power_begin", 32'(state), 32'd1);
    cyc(0, 0, 0, 0);
    check("auto_set", 32'(state), 32'd2);
    check("p0_f7", 32'(msg[25:23]), 32'd2);
    check("p0_f0", 32'(msg[2:0]), 32'd4);
    check("p0_msg", 32'(msg), 32'(P0));

    cyc(0, 0, 1, 0);
    check("mode_p1", 32'(msg), 32'(P1));
    cyc(0, 0, 1, 0);
    check("mode_p2", 32'(msg), 32'(P2));
    cyc(0, 0, 1, 0);
    check("mode_p3", 32'(msg), 32'(P3));
    cyc(0, 0, 0, 1);
    check("set_tick_ignored", 32'(msg), 32'(P3));
    check("set_stays", 32'(state), 32'd2);

    cyc(0, 1, 0, 0);
    check("start_run", 32'(state), 32'd3);
    check("run_msg_p3", 32'(msg), 32'(P3));
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);
    check("p3_f2_done", 32'(msg), 32'd5);
    check("p3_still_run", 32'(state), 32'd3);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
    check("p3_f0_one", 32'(msg), 32'd1);
    check("p3_no_buzz", 32'(buzzer), 32'd0);
    cyc(0, 0, 0, 1);
    check("finish_state", 32'(state), 32'd6);
    check("finish_msg", 32'(msg), 32'd0);
    check("finish_buzzer", 32'(buzzer), 32'd1);

    cyc(0, 0, 0, 0);
    check("finish_hold_idle", 32'(state), 32'd6);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    check("finish_hold_2", 32'(state), 32'd6);
    check("finish_buzz_2", 32'(buzzer), 32'd1);
    cyc(0, 0, 0, 1);
    check("finish_to_off", 32'(state), 32'd0);
    check("off_msg", 32'(msg), 32'd0);
    check("off_buzzer", 32'(buzzer), 32'd0);

    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("reload_p0", 32'(msg), 32'(P0));
    cyc(0, 0, 1, 0);
    check("reload_p1", 32'(msg), 32'(P1));
    cyc(0, 1, 0, 0);
    check("p1_run", 32'(state), 32'd3);
    cyc(0, 1, 0, 1);
    check("start_tick_pause", 32'(state), 32'd5);
    check("start_tick_f6", 32'(msg[22:19]), 32'd5);
    cyc(0, 0, 0, 1);
    check("pause_frozen", 32'(msg), 32'(P1));
    cyc(0, 1, 0, 0);
    check("resume_run", 32'(state), 32'd3);
    cyc(0, 0, 0, 1);
    check("p1_f6_dec", 32'(msg), 32'(P1D));

    lid_open = 1'b1;
    step();
`ifdef WASH_LID_LOCK_EN
    check("lid_error", 32'(state), 32'd4);
    check("lid_buzzer", 32'(buzzer), 32'd1);
`else
    check("lid_ignored", 32'(state), 32'd3);
    check("lid_no_buzz", 32'(buzzer), 32'd0);
`endif
    lid_open = 1'b0;
    step();
`ifdef WASH_LID_LOCK_EN
    check("lid_close_pause", 32'(state), 32'd5);
    check("pause_buzz_off", 32'(buzzer), 32'd0);
    cyc(0, 1, 0, 0);
    check("lid_resume", 32'(state), 32'd3);
`else
    check("lid_close_run", 32'(state), 32'd3);
    check("run_buzz_off", 32'(buzzer), 32'd0);
    cyc(0, 1, 0, 0);
    check("nolock_pause", 32'(state), 32'd5);
`endif
    check("lid_msg_kept", 32'(msg), 32'(P1D));

    cyc(1, 0, 0, 0);
    check("power_off", 32'(state), 32'd0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("p0_after_off", 32'(msg), 32'(P0));
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1);
    check("p0_f7_dec", 32'(msg), 32'(P0D));
    cyc(1, 0, 0, 0);
    check("power_midrun_state", 32'(state), 32'd0);
    check("power_midrun_msg", 32'(msg), 32'd0);
    check("power_midrun_buzz", 32'(buzzer), 32'd0);

    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1);
    check("pre_reset_run", 32'(state), 32'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrun_reset_state", 32'(state), 32'd0);
    check("midrun_reset_msg", 32'(msg), 32'd0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("preset_lost", 32'(msg), 32'(P0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
